// File: rtl/ltl_report_collector.sv
// Timestamps LTL monitor report lines and queues them in a FIFO drained over valid/ready.
// Optional LTL_REPORT_EDGE_EN: queue a report bit only on its 0->1 transition.
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int SYM_W       = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int CYCLE_W     = 32,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [SYM_W-1:0]       symbols,
  input  logic [NUM_REPORTS-1:0] report_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_REPORTS-1:0] out_report_vec,
  output logic [CYCLE_W-1:0]     out_cycle,
  output logic [SYM_W-1:0]       out_symbol,
  output logic                   overflow,
  output logic [CNT_W-1:0]       report_count,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [NUM_REPORTS-1:0] r_mem_vec [FIFO_DEPTH];
  logic [CYCLE_W-1:0]     r_mem_cyc [FIFO_DEPTH];
  logic [SYM_W-1:0]       r_mem_sym [FIFO_DEPTH];

  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_occ;
  logic [CYCLE_W-1:0]     r_cycle_ctr;
  logic [CYCLE_W-1:0]     r_cyc_d;
  logic [SYM_W-1:0]       r_sym_d;
  logic                   r_run_d;
  logic                   r_overflow;
  logic [CNT_W-1:0]       r_rep_cnt;
  logic [CNT_W-1:0]       r_drop_cnt;

  logic [NUM_REPORTS-1:0] w_cand;
  logic                   w_valid;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_accept;
  logic                   w_drop;

`ifdef LTL_REPORT_EDGE_EN
  logic [NUM_REPORTS-1:0] r_prev_report;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_report <= '0;
    end else if (r_run_d) begin
      r_prev_report <= report_in;
    end
  end

  assign w_cand = report_in & ~r_prev_report;
`else
  assign w_cand = report_in;
`endif

  assign w_valid  = (r_occ != '0);
  assign w_pop    = w_valid & out_ready;
  assign w_push   = r_run_d & (|w_cand);
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_accept = w_push & ((r_occ != DEPTH_C) | w_pop);
  assign w_drop   = w_push & ~w_accept;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_vec[r_wr_ptr] <= w_cand;
      r_mem_cyc[r_wr_ptr] <= r_cyc_d;
      r_mem_sym[r_wr_ptr] <= r_sym_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_cycle_ctr <= '0;
      r_cyc_d     <= '0;
      r_sym_d     <= '0;
      r_run_d     <= 1'b0;
      r_overflow  <= 1'b0;
      r_rep_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_run_d <= run;
      if (run) begin
        r_sym_d     <= symbols;
        r_cyc_d     <= r_cycle_ctr;
        r_cycle_ctr <= r_cycle_ctr + 1'b1;
      end
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_rep_cnt != '1) begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_accept & ~w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (~w_accept & w_pop) begin
        r_occ <= r_occ - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end
    end
  end

  assign out_valid      = w_valid;
  assign out_report_vec = w_valid ? r_mem_vec[r_rd_ptr] : '0;
  assign out_cycle      = w_valid ? r_mem_cyc[r_rd_ptr] : '0;
  assign out_symbol     = w_valid ? r_mem_sym[r_rd_ptr] : '0;
  assign overflow       = r_overflow;
  assign report_count   = r_rep_cnt;
  assign drop_count     = r_drop_cnt;

endmodule
